mem_resp: RTL and testbench
===========================

Name: mem_resp

Overview:
- Memory-side responder for the core's address/data request interface: the target end of the address path the core drives from PC or ALU.
- Accepts one word-aligned read or byte-masked write per request.
- Inserts a configurable number of wait states, then returns a one-cycle response pulse with data and an error flag.
- Backs the core's instruction fetch and load/store traffic with an internal byte-enabled word RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the internal RAM (power of two).
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- req_valid  input  1  request present.
- req_we  input  1  1 = write, 0 = read.
- req_be  input  4  byte enables for writes; bit i = byte lane i (bits 8i+7:8i); ignored on reads.
- req_addr  input  REG_LEN  byte address.
- req_wdata  input  REG_LEN  write data.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse; response fields valid.
- rsp_rdata  output  REG_LEN  read data; 0 for writes and on error.
- rsp_err  output  1  request was misaligned or out of range.
- busy  output  1  request in flight (accepted, response not yet given); the core holds PC while busy.

Behaviour:
- Clock and reset: single clock domain.
  - Synchronous active-high reset: on posedge clk with rst=1, state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not reset.
  - rst has priority over every other event, including a request accepted in the same cycle and a request in flight. An in-flight request is dropped: no write and no response.
- FSM states and transitions: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On accept (req_valid & req_ready), latch we/be/addr/wdata. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: req_ready=0, busy=1. Counter counts 1..WAIT_STATES. On the last count, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle. req_ready=1, so back-to-back requests are allowed. A request accepted in RESP follows the same transitions as one accepted in IDLE. With no request, go to IDLE.
- RAM access timing: happens on the clock edge entering RESP. The read is registered into rsp_rdata; the write is committed on that edge.
- Latency: accept edge to rsp_valid high is WAIT_STATES+1 cycles. Sustained throughput is one request per WAIT_STATES+1 cycles.
- busy: 1 from the cycle after accept until the cycle before RESP, i.e. while in WAIT or in the RESP-bound transition. busy=0 in IDLE and RESP.
- Error conditions:
  - addr[1:0]!=0 is misaligned.
  - addr >= 4*DEPTH_WORDS is out of range.
  - Either gives rsp_err=1, rsp_rdata=0, and no RAM write. The error response is still delivered with full latency.
- Word index: addr[log2(DEPTH_WORDS)+1:2].
- Writes:
  - Only lanes with be=1 are updated; the other lanes keep their old value.
  - be=4'b0000 on a write is legal: no change, rsp_err=0.
  - rsp_rdata=0 on writes.
- Reads: return the full word as it stands before any write in the same response edge; only one request is in flight, so there is no internal hazard.
- Back-to-back ordering: a read of an address written by the immediately preceding request returns the new data.
- Inputs outside an accept cycle are don't-care; the responder uses only latched copies.
- req_valid deasserted while not ready: no effect. The requester need not hold the request.

Decomposition:
- rysy_pkg.vh additions:
  - MEM_BE_W (4).
  - State encodings MEM_IDLE=2'b00, MEM_WAIT=2'b01, MEM_RESP=2'b10.
  - Uses the existing REG_LEN.
- Sub-module mem_array: synchronous single-port RAM, DEPTH_WORDS x REG_LEN. Ports: clk, en, we, be[3:0], idx, wdata, rdata (registered). Per-lane write enable.
- mem_resp contains the FSM, wait counter, request latch, address checks and response muxing.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT after a write request to 0x10 -> rsp_valid never pulses; a subsequent read of 0x10 returns its old contents; outputs are 0 after reset.
- Basic write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x40 with be=4'hF, then read 0x40 -> each rsp_valid arrives 2 cycles after accept; read rdata=0xDEADBEEF, err=0.
- Byte mask: after the previous scenario, write 0x11223344 to 0x40 with be=4'b0101, then read -> 0xDE22BE44.
- Errors: read 0x42 -> err=1, rdata=0. Write to 0x1000 (DEPTH_WORDS=1024) -> err=1, and the word at 0x0 is unchanged. Both responses use full latency.
- Back-to-back, WAIT_STATES=0: hold req_valid; write 0xA5A5A5A5 to 0x8, then read 0x8 on the RESP cycle -> rsp_valid on consecutive cycles; read returns 0xA5A5A5A5.
- Latency sweep: WAIT_STATES=3, read -> accept-to-rsp_valid = 4 cycles; busy high for exactly 3 cycles; req_ready low during WAIT.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder: bus widths, FSM state
// encoding and the request address check.
package mem_resp_pkg;

    localparam int REG_LEN  = 32;
    localparam int MEM_BE_W = 4;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_RESP = 2'b10
    } mem_state_e;

    // A request is bad when it is not word aligned or lies past the last RAM word.
    function automatic logic addr_bad(input logic [REG_LEN-1:0] addr, input int idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != '0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with per-byte-lane write enables and a registered,
// read-before-write data output.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [MEM_BE_W-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [REG_LEN-1:0]  wdata,
    output logic [REG_LEN-1:0]  rdata
);

    logic [REG_LEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            if (we) begin
                for (int i = 0; i < MEM_BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_resp.sv
// Memory-side responder: accepts one read or byte-masked write at a time,
// waits WAIT_STATES cycles, then pulses a response with data and error flag.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [MEM_BE_W-1:0] req_be,
    input  logic [REG_LEN-1:0]  req_addr,
    input  logic [REG_LEN-1:0]  req_wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [REG_LEN-1:0]  rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    mem_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept;
    logic       enter_resp;

    logic                we_p0;
    logic [MEM_BE_W-1:0] be_p0;
    logic [REG_LEN-1:0]  addr_p0;
    logic [REG_LEN-1:0]  wdata_p0;

    logic                cur_we;
    logic [MEM_BE_W-1:0] cur_be;
    logic [REG_LEN-1:0]  cur_addr;
    logic [REG_LEN-1:0]  cur_wdata;
    logic                cur_err;

    logic                rd_ok_p1;
    logic                err_p1;
    logic [REG_LEN-1:0]  ram_rdata;

    assign req_ready = (state != MEM_WAIT);
    assign busy      = (state == MEM_WAIT);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        unique case (state)
            MEM_WAIT: begin
                if (cnt == WS) begin
                    state_nxt  = MEM_RESP;
                    cnt_nxt    = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                if (accept) begin
                    if (WS == 4'd0) begin
                        state_nxt  = MEM_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = MEM_WAIT;
                        cnt_nxt   = 4'd1;
                    end
                end else begin
                    state_nxt = MEM_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_IDLE;
            cnt      <= '0;
            rd_ok_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_ok_p1 <= enter_resp && !cur_we && !cur_err;
            err_p1   <= enter_resp && cur_err;
        end
    end

    // ---- stage 0: request latch ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            be_p0    <= req_be;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // With zero wait states the RAM edge coincides with the accept edge, so the live request is used.
    always_comb begin
        if (state != MEM_WAIT) begin
            cur_we    = req_we;
            cur_be    = req_be;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_p0;
            cur_be    = be_p0;
            cur_addr  = addr_p0;
            cur_wdata = wdata_p0;
        end
        cur_err = addr_bad(cur_addr, IDX_W);
    end

    // ---- stage 1: RAM access on the edge entering RESP ----
    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk   (clk),
        .en    (enter_resp && !cur_err && !rst),
        .we    (cur_we),
        .be    (cur_be),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_valid = (state == MEM_RESP);
    assign rsp_err   = err_p1;
    assign rsp_rdata = rd_ok_p1 ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: three instances with WAIT_STATES = 1, 0 and 3
// exercised from a vector table plus reset, back-to-back and latency sequences.
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [3:0]  req_be    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_we(req_we[0]), .req_be(req_be[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

    mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_we(req_we[1]), .req_be(req_be[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

    mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_we(req_we[2]), .req_be(req_be[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge while instance k is ready; returns at the negedge where rsp_valid is seen.
    task automatic do_req(input int k, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int nbusy, output int nnrdy);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_be[k]    = be;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_wdata[k] = 32'hX;
        req_addr[k]  = 32'hX;
        lat   = 1;
        nbusy = 0;
        nnrdy = 0;
        while (!rsp_valid[k] && lat < 40) begin
            if (busy[k]) nbusy++;
            if (!req_ready[k]) nnrdy++;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[k]) begin
            vec++;
            miss++;
            $display("FAIL rsp_timeout: inst %0d got no rsp_valid, required within 40 cycles", k);
        end
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, nb, nr;

        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_be[k]    = 4'h0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
        end

        tbl[0]  = '{1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 4'h5, 32'h0000_0040, 32'h1122_3344, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1357_9BDF, 32'h0000_0000, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 32'h0000_0042, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h1357_9BDF, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
        tbl[10] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h89AB_CDEF, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0000_0000, 32'h89AB_CDEF, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'h0);
            check($sformatf("reset_rsp_err[%0d]", k),   32'(rsp_err[k]),   32'h0);
            check($sformatf("reset_rsp_rdata[%0d]", k), rsp_rdata[k],      32'h0);
            check($sformatf("reset_busy[%0d]", k),      32'(busy[k]),      32'h0);
            check($sformatf("reset_ready[%0d]", k),     32'(req_ready[k]), 32'h1);
        end

        // Table: WAIT_STATES=1 instance
        for (int i = 0; i < 12; i++) begin
            do_req(0, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, rd, er, lat, nb, nr);
            check($sformatf("tbl%0d_rdata", i),   rd,        tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i),     32'(er),   32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_latency", i), 32'(lat),  32'd2);
            check($sformatf("tbl%0d_busy", i),    32'(nb),   32'd1);
            check($sformatf("tbl%0d_notready", i), 32'(nr),  32'd1);
            @(negedge clk);
            check($sformatf("tbl%0d_pulse_end", i), 32'(rsp_valid[0]), 32'h0);
        end

        // Reset mid-WAIT drops an in-flight write to 0x10
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, rd, er, lat, nb, nr);
        check("pre_reset_write_err", 32'(er), 32'h0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_be[0]    = 4'hF;
        req_addr[0]  = 32'h10;
        req_wdata[0] = 32'h0BAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("inflight_busy", 32'(busy[0]), 32'h1);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst_no_rsp%0d", c), 32'(rsp_valid[0]), 32'h0);
        end
        rst = 1'b0;
        check("post_rst_rdata", rsp_rdata[0],      32'h0);
        check("post_rst_err",   32'(rsp_err[0]),   32'h0);
        check("post_rst_busy",  32'(busy[0]),      32'h0);
        check("post_rst_ready", 32'(req_ready[0]), 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_no_rsp%0d", c), 32'(rsp_valid[0]), 32'h0);
        end
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat, nb, nr);
        check("post_rst_read_0x10", rd,      32'hCAFE_F00D);
        check("post_rst_read_err",  32'(er), 32'h0);
        @(negedge clk);

        // Back-to-back on the WAIT_STATES=0 instance: write then read in the RESP cycle
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_be[1]    = 4'hF;
        req_addr[1]  = 32'h8;
        req_wdata[1] = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        check("b2b_wr_valid", 32'(rsp_valid[1]), 32'h1);
        check("b2b_wr_rdata", rsp_rdata[1],      32'h0);
        check("b2b_wr_err",   32'(rsp_err[1]),   32'h0);
        check("b2b_ready",    32'(req_ready[1]), 32'h1);
        check("b2b_busy",     32'(busy[1]),      32'h0);
        req_we[1]    = 1'b0;
        req_wdata[1] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("b2b_rd_valid", 32'(rsp_valid[1]), 32'h1);
        check("b2b_rd_rdata", rsp_rdata[1],      32'hA5A5_A5A5);
        check("b2b_rd_err",   32'(rsp_err[1]),   32'h0);
        @(negedge clk);
        check("b2b_idle", 32'(rsp_valid[1]), 32'h0);

        // Latency sweep on the WAIT_STATES=3 instance
        do_req(2, 1'b1, 4'hF, 32'h20, 32'h0F0F_1234, rd, er, lat, nb, nr);
        check("ws3_wr_latency", 32'(lat), 32'd4);
        @(negedge clk);
        do_req(2, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, nb, nr);
        check("ws3_rd_latency",  32'(lat),         32'd4);
        check("ws3_busy_cycles", 32'(nb),          32'd3);
        check("ws3_notready",    32'(nr),          32'd3);
        check("ws3_rdata",       rd,               32'h0F0F_1234);
        check("ws3_resp_busy",   32'(busy[2]),     32'h0);
        check("ws3_resp_ready",  32'(req_ready[2]), 32'h1);
        @(negedge clk);
        do_req(2, 1'b0, 4'h0, 32'h0000_2000, 32'h0, rd, er, lat, nb, nr);
        check("ws3_oor_latency", 32'(lat), 32'd4);
        check("ws3_oor_err",     32'(er),  32'h1);
        check("ws3_oor_rdata",   rd,       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded 200000, required completion");
        $fatal(1);
    end

endmodule
